shift_reg_piso_ctrl: RTL and testbench

Parametrised parallel-in / serial-out shift register with load handshake, bit counter and frame control. It accepts an M-bit word over a valid/ready handshake, serialises it LSB- or MSB-first, and advances one bit per `shift` strobe. It reports per-bit validity, busy and end-of-frame. It sits between a parallel data source and a serial line driver, replacing free-running shift registers that have no framing or completion indication.

---
 rtl/shift_reg_piso_ctrl.sv | 130 +++++++++++++
 tb/tb_shift_reg_piso_ctrl.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/shift_reg_piso_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : shift_reg_piso_ctrl
// Description : Parallel-in/serial-out shift register with a valid/ready load
//               handshake, a bit counter and frame completion signalling.
//               Optional even-parity trailer bit: SHIFT_REG_PISO_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_reg_piso_ctrl #(
  parameter int unsigned M         = 8,
  parameter bit          MSB_FIRST = 1'b0,
  parameter logic        FILL      = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [M-1:0] bus_in,
  input  logic         load_valid,
  output logic         load_ready,
  input  logic         shift,
  output logic         bit_out,
  output logic         bit_valid,
  output logic         busy,
  output logic         done
);

  localparam int unsigned CW = $clog2(M);
  localparam logic [CW-1:0] C_LAST = CW'(M - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
`ifdef SHIFT_REG_PISO_PARITY_EN
    S_PARITY = 2'd2,
`endif
    S_SHIFT  = 2'd1
  } state_e;

  state_e        state_q, state_d;
  logic [M-1:0]  shreg_q, shreg_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic          done_q,  done_d;
`ifdef SHIFT_REG_PISO_PARITY_EN
  logic          par_q,   par_d;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
`ifdef SHIFT_REG_PISO_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
`ifdef SHIFT_REG_PISO_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
`ifdef SHIFT_REG_PISO_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (load_valid) begin
          state_d = S_SHIFT;
          shreg_d = bus_in;
          cnt_d   = '0;
`ifdef SHIFT_REG_PISO_PARITY_EN
          par_d   = ^bus_in;
`endif
        end
      end
      S_SHIFT: begin
        if (shift) begin
          // Move the next bit toward the output end; FILL backfills the far end.
          if (MSB_FIRST) shreg_d = {shreg_q[M-2:0], FILL};
          else           shreg_d = {FILL, shreg_q[M-1:1]};
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == C_LAST) begin
            cnt_d = '0;
`ifdef SHIFT_REG_PISO_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_IDLE;
            done_d  = 1'b1;
`endif
          end
        end
      end
`ifdef SHIFT_REG_PISO_PARITY_EN
      S_PARITY: begin
        if (shift) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bit_out = FILL;
    case (state_q)
      S_SHIFT:  bit_out = MSB_FIRST ? shreg_q[M-1] : shreg_q[0];
`ifdef SHIFT_REG_PISO_PARITY_EN
      S_PARITY: bit_out = par_q;
`endif
      default:  bit_out = FILL;
    endcase
  end

  assign load_ready = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign bit_valid  = (state_q != S_IDLE);
  assign done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_reg_piso_ctrl.sv
`default_nettype none
// Directed bench: an LSB-first and an MSB-first instance share one stimulus
// stream; expected serial bits are derived from the loaded word.
module tb_shift_reg_piso_ctrl;

`ifdef SHIFT_REG_PISO_PARITY_EN
  localparam int FB = 9;
`else
  localparam int FB = 8;
`endif

  logic       clk, reset, load_valid, shift;
  logic [7:0] bus_in;
  logic       lr0, bo0, bv0, bz0, dn0;
  logic       lr1, bo1, bv1, bz1, dn1;
  int         n_checks = 0;
  int         n_pass   = 0;

  shift_reg_piso_ctrl #(.M(8), .MSB_FIRST(1'b0), .FILL(1'b1)) u_lsb (
    .clk(clk), .reset(reset), .bus_in(bus_in), .load_valid(load_valid),
    .load_ready(lr0), .shift(shift), .bit_out(bo0), .bit_valid(bv0),
    .busy(bz0), .done(dn0));

  shift_reg_piso_ctrl #(.M(8), .MSB_FIRST(1'b1), .FILL(1'b1)) u_msb (
    .clk(clk), .reset(reset), .bus_in(bus_in), .load_valid(load_valid),
    .load_ready(lr1), .shift(shift), .bit_out(bo1), .bit_valid(bv1),
    .busy(bz1), .done(dn1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic exp_bit(input logic [7:0] w, input int i, input bit msb);
    if (i >= 8) return ^w;
    return msb ? w[7-i] : w[i];
  endfunction

  task automatic check_idle(input string tag, input logic exp_done);
    check({tag, "_ready"}, {31'd0, lr0 & lr1}, 32'd1);
    check({tag, "_busy"},  {30'd0, bz0, bz1}, 32'd0);
    check({tag, "_valid"}, {30'd0, bv0, bv1}, 32'd0);
    check({tag, "_bitout"},{30'd0, bo0, bo1}, 32'd3);
    check({tag, "_done"},  {30'd0, dn0, dn1}, exp_done ? 32'd3 : 32'd0);
  endtask

  task automatic start_load(input logic [7:0] w, input logic sh);
    check("ready_before_load", {31'd0, lr0}, 32'd1);
    bus_in     = w;
    load_valid = 1'b1;
    shift      = sh;
    @(negedge clk);
  endtask

  // lv_mode: 0 = load_valid low, 1 = load_valid toggling with junk data,
  // 2 = load_valid held high presenting the next word.
  task automatic run_bits(input logic [7:0] w, input int every, input int lv_mode,
                          input logic [7:0] nxt);
    for (int i = 0; i < FB; i++) begin
      for (int r = 0; r < every; r++) begin
        check("bit_lsb", {31'd0, bo0}, {31'd0, exp_bit(w, i, 1'b0)});
        check("bit_msb", {31'd0, bo1}, {31'd0, exp_bit(w, i, 1'b1)});
        check("bit_valid", {30'd0, bv0, bv1}, 32'd3);
        check("busy", {30'd0, bz0, bz1}, 32'd3);
        check("ready_low", {30'd0, lr0, lr1}, 32'd0);
        check("done_low", {30'd0, dn0, dn1}, 32'd0);
        shift = (r == every - 1);
        case (lv_mode)
          1:       begin load_valid = ~load_valid; bus_in = 8'($urandom); end
          2:       begin load_valid = 1'b1; bus_in = nxt; end
          default: load_valid = 1'b0;
        endcase
        @(negedge clk);
      end
    end
    check_idle("done_cycle", 1'b1);
    load_valid = (lv_mode == 2);
    if (lv_mode == 2) bus_in = nxt;
  endtask

  task automatic idle_after();
    load_valid = 1'b0;
    shift      = 1'b1;
    @(negedge clk);
    check_idle("post_frame", 1'b0);
  endtask

  initial begin
    reset = 1'b0; load_valid = 1'b0; shift = 1'b0; bus_in = 8'h00;
    @(negedge clk);
    check_idle("reset", 1'b0);
    reset = 1'b1;
    shift = 1'b1;
    @(negedge clk);
    check_idle("idle_shift_ignored", 1'b0);

    start_load(8'hC1, 1'b1);
    run_bits(8'hC1, 1, 0, 8'h00);
    idle_after();

    start_load(8'hFF, 1'b0);
    run_bits(8'hFF, 2, 1, 8'h00);
    idle_after();

    // Abort a frame after three consumed bits.
    start_load(8'h3C, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check("pre_abort_lsb", {31'd0, bo0}, {31'd0, exp_bit(8'h3C, i, 1'b0)});
      check("pre_abort_msb", {31'd0, bo1}, {31'd0, exp_bit(8'h3C, i, 1'b1)});
      @(negedge clk);
    end
    reset = 1'b0;
    #1;
    check_idle("abort", 1'b0);
    @(negedge clk);
    reset = 1'b1;
    shift = 1'b0;
    load_valid = 1'b0;
    @(negedge clk);
    check_idle("after_abort", 1'b0);
    start_load(8'h0F, 1'b1);
    run_bits(8'h0F, 1, 0, 8'h00);
    idle_after();

    // Back-to-back frames with load_valid held high.
    start_load(8'hAA, 1'b1);
    run_bits(8'hAA, 1, 2, 8'h55);
    @(negedge clk);
    load_valid = 1'b0;
    run_bits(8'h55, 1, 0, 8'h00);
    idle_after();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
